// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets four byte-stream requesters share one UART
// transmit path. The arbiter is message-atomic: once a requester is granted,
// it keeps the UART until it delivers a byte flagged `last`. Bytes from
// different messages therefore never interleave on the serial line.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   If the owner leaves req_valid low for TimeoutCycles consecutive
//   idle cycles, its grant is withdrawn and timeout_flag is set. timeout_flag
//   is sticky and is cleared only by reset. Without the macro, an owner may
//   hold the UART indefinitely and timeout_flag is tied low.
//
// Parameters
//   DataLength     byte width, matches the UART transmit width
//   TimeoutCycles  owner-idle cycles before a forced release (timeout build only)
//
// Ports
//   clock          system clock, all logic on its rising edge
//   reset          synchronous active-low reset
//   req_valid[4]   requester i presents a byte
//   req_data       packed bytes, requester i at [i*DataLength +: DataLength]
//   req_last[4]    requester i's byte ends its message
//   req_ack[4]     combinational: requester i's byte is taken this cycle
//   grant[4]       registered one-hot owner (zero when idle)
//   tx_full        UART TX FIFO full
//   write_to_uart  registered one-cycle write strobe
//   tx_data        registered byte, valid with write_to_uart
//   busy           registered, high while a requester owns the UART
//   timeout_flag   registered sticky forced-release indicator
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int          DataLength    = 8,
  parameter logic [15:0] TimeoutCycles = 16'd50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              req_valid,
  input  logic [4*DataLength-1:0] req_data,
  input  logic [3:0]              req_last,
  output logic [3:0]              req_ack,
  output logic [3:0]              grant,
  input  logic                    tx_full,
  output logic                    write_to_uart,
  output logic [DataLength-1:0]   tx_data,
  output logic                    busy,
  output logic                    timeout_flag
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [3:0]            r_grant,   w_grant_nxt;
  logic [1:0]            r_owner,   w_owner_nxt;
  logic [1:0]            r_ptr,     w_ptr_nxt;
  logic                  r_write,   w_write_nxt;
  logic [DataLength-1:0] r_tx_data, w_tx_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]           r_count,   w_count_nxt;
  logic                  r_timeout_flag, w_timeout_flag_nxt;
`endif

  logic                  w_hit;
  logic [1:0]            w_pick;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic [DataLength-1:0] w_owner_data;
  logic                  w_accept;

  // Round-robin search: scan from r_ptr upward with 2-bit wrap. The loop runs
  // from the farthest offset to the nearest so the nearest hit is the last
  // (winning) assignment.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[r_ptr + 2'(k)]) begin
        w_hit  = 1'b1;
        w_pick = r_ptr + 2'(k);
      end
    end
  end

  assign w_owner_valid = req_valid[r_owner];
  assign w_owner_last  = req_last[r_owner];
  assign w_owner_data  = req_data[r_owner*DataLength +: DataLength];

  // The !r_write term spaces accepts two cycles apart so tx_full reflects the
  // previous write before another byte is taken.
  assign w_accept = (r_state == ST_BUSY) && w_owner_valid && !tx_full && !r_write;
  assign req_ack  = w_accept ? (4'b0001 << r_owner) : 4'b0000;

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_write_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    w_count_nxt        = r_count;
    w_timeout_flag_nxt = r_timeout_flag;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        w_count_nxt = '0;
`endif
        if (w_hit) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = 4'b0001 << w_pick;
          w_owner_nxt = w_pick;
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
          w_write_nxt   = 1'b1;
          w_tx_data_nxt = w_owner_data;
`ifdef UART_ARB_TIMEOUT_EN
          w_count_nxt   = '0;
`endif
          if (w_owner_last) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 4'b0000;
            w_ptr_nxt   = r_owner + 2'd1;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Only owner-idle cycles count; a tx_full stall keeps valid high.
        else if (!w_owner_valid) begin
          if (r_count == TimeoutCycles - 16'd1) begin
            w_state_nxt        = ST_IDLE;
            w_grant_nxt        = 4'b0000;
            w_ptr_nxt          = r_owner + 2'd1;
            w_count_nxt        = '0;
            w_timeout_flag_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + 16'd1;
          end
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 4'b0000;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd0;
      r_write   <= 1'b0;
      r_tx_data <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_count        <= '0;
      r_timeout_flag <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_write   <= w_write_nxt;
      r_tx_data <= w_tx_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_count        <= w_count_nxt;
      r_timeout_flag <= w_timeout_flag_nxt;
`endif
    end
  end

  assign grant         = r_grant;
  assign write_to_uart = r_write;
  assign tx_data       = r_tx_data;
  assign busy          = (r_state == ST_BUSY);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_flag = r_timeout_flag;
`else
  logic w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = ^TimeoutCycles;
  assign timeout_flag            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Each requester is modelled as a small
// table of {last, byte} entries presented in order; an entry is retired when
// the DUT acknowledges it. Bytes leaving on write_to_uart and new grants are
// logged with their cycle numbers and compared against hand-computed values.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_last;
  logic [3:0]    req_ack;
  logic [3:0]    grant;
  logic          tx_full;
  logic          write_to_uart;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          timeout_flag;

  uart_tx_arbiter #(
    .DataLength    (DW),
    .TimeoutCycles (16'd10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .tx_full       (tx_full),
    .write_to_uart (write_to_uart),
    .tx_data       (tx_data),
    .busy          (busy),
    .timeout_flag  (timeout_flag)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Requester tables: {last, byte}
  logic [8:0] src [4][8];
  int         src_len [4];
  int         src_rd  [4];

  // Output and grant logs
  logic [7:0] out_bytes [64];
  int         out_cyc   [64];
  int         out_n;
  logic [3:0] grant_log [32];
  int         grant_cyc [32];
  int         grant_n;
  logic [3:0] prev_grant;

  int cyc       = 0;
  int ack_total = 0;
  int bad_ack   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_rd[i]  = 0;
    end
  endtask

  task automatic load(input int i, input int idx, input logic last, input logic [7:0] d);
    src[i][idx] = {last, d};
    if (src_len[i] < idx + 1) src_len[i] = idx + 1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_rd[i] < src_len[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src[i][src_rd[i]][7:0];
        req_last[i]           = src[i][src_rd[i]][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = 8'h00;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock cycle: present inputs, observe at the falling edge, then move
  // to 1 ns past the next rising edge.
  task automatic step();
    drive();
    @(negedge clock);
    if ((req_ack & ~grant) != 4'b0000) bad_ack++;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        src_rd[i]++;
        ack_total++;
      end
    end
    if (write_to_uart && out_n < 64) begin
      out_bytes[out_n] = tx_data;
      out_cyc[out_n]   = cyc;
      out_n++;
    end
    if (grant != 4'b0000 && prev_grant == 4'b0000 && grant_n < 32) begin
      grant_log[grant_n] = grant;
      grant_cyc[grant_n] = cyc;
      grant_n++;
    end
    prev_grant = grant;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_until_out(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (out_n < n && k < budget) begin
      step();
      k++;
    end
    check(tag, out_n, n);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    tx_full = 1'b0;
    clear_src();
    step();
    step();
    reset      = 1'b1;
    out_n      = 0;
    grant_n    = 0;
    prev_grant = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_cont [6];
    logic [3:0] exp_rr   [5];
    logic [3:0] exp_g_a;
    logic [3:0] exp_g_b;
    logic       exp_f_a;
    int t0, a0, w0, tr;

    exp_cont = '{8'h30, 8'h31, 8'h32, 8'h41, 8'h42, 8'h43};
    exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset     = 1'b0;
    tx_full   = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    req_last  = 4'b0000;
    clear_src();
    out_n = 0; grant_n = 0; prev_grant = 4'b0000;
    @(posedge clock);
    #1;

    // ---- Reset state; IDLE never acknowledges ----
    do_reset();
    check("rst_grant", grant, 4'b0000);
    check("rst_write", write_to_uart, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_flag", timeout_flag, 1'b0);
    for (int i = 0; i < 4; i++) load(i, 0, 1'b1, 8'hEE);
    drive();
    #1;
    check("idle_no_ack", req_ack, 4'b0000);

    // ---- Single message from requester 2 ----
    do_reset();
    load(2, 0, 1'b0, 8'h48);
    load(2, 1, 1'b1, 8'h69);
    t0 = cyc;
    run_until_out("single_count", 2, 20);
    step();
    step();
    check("single_grant", grant_log[0], 4'b0100);
    check("single_grant_latency", grant_cyc[0] - t0, 1);
    check("single_byte0", out_bytes[0], 8'h48);
    check("single_byte1", out_bytes[1], 8'h69);
    check("single_first_write", out_cyc[0] - t0, 2);
    check("single_spacing", out_cyc[1] - out_cyc[0], 2);
    check("single_release_grant", grant, 4'b0000);
    check("single_release_busy", busy, 1'b0);
    // Pointer now 3: requester 3 wins over requester 0.
    load(0, 0, 1'b1, 8'h01);
    load(3, 0, 1'b1, 8'h03);
    run_until_out("ptr_count", 4, 20);
    check("ptr_first_grant", grant_log[1], 4'b1000);
    check("ptr_second_grant", grant_log[2], 4'b0001);
    check("ptr_byte_a", out_bytes[2], 8'h03);
    check("ptr_byte_b", out_bytes[3], 8'h01);

    // ---- Contention: requesters 0 and 3, 3-byte messages ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      load(0, k, k == 2, 8'h30 + 8'(k));
      load(3, k, k == 2, 8'h41 + 8'(k));
    end
    run_until_out("cont_count", 6, 60);
    for (int k = 0; k < 6; k++)
      check($sformatf("cont_byte%0d", k), out_bytes[k], exp_cont[k]);
    check("cont_grant0", grant_log[0], 4'b0001);
    check("cont_grant1", grant_log[1], 4'b1000);

    // ---- Round-robin fairness: four requesters, 1-byte messages ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 0, 1'b1, 8'hA0 + 8'(i));
      load(i, 1, 1'b1, 8'hB0 + 8'(i));
    end
    run_until_out("rr_count", 5, 60);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_grant%0d", k), grant_log[k], exp_rr[k]);
    check("rr_byte4", out_bytes[4], 8'hB0);

    // ---- Backpressure: tx_full for 20 cycles mid-message ----
    do_reset();
    load(1, 0, 1'b0, 8'h10);
    load(1, 1, 1'b0, 8'h11);
    load(1, 2, 1'b0, 8'h12);
    load(1, 3, 1'b1, 8'h13);
    run_until_out("bp_pre_count", 2, 20);
    a0 = ack_total;
    w0 = out_n;
    tx_full = 1'b1;
    repeat (20) step();
    check("bp_no_ack", ack_total - a0, 0);
    check("bp_no_write", out_n - w0, 0);
    check("bp_grant_held", grant, 4'b0010);
    check("bp_busy_held", busy, 1'b1);
    tx_full = 1'b0;
    tr = cyc;
    run_until_out("bp_post_count", 4, 20);
    check("bp_byte2", out_bytes[2], 8'h12);
    check("bp_byte3", out_bytes[3], 8'h13);
    check("bp_resume_latency", out_cyc[2] - tr, 1);
    check("bp_resume_spacing", out_cyc[3] - out_cyc[2], 2);

    // ---- Reset in the middle of a message ----
    do_reset();
    for (int k = 0; k < 4; k++) load(2, k, k == 3, 8'h50 + 8'(k));
    run_until_out("mid_pre_count", 1, 20);
    clear_src();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_write", write_to_uart, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    w0 = out_n;
    repeat (5) step();
    check("mid_rst_no_more_writes", out_n, w0);

    // ---- Owner goes silent after one non-last byte; requester 2 waits ----
`ifdef UART_ARB_TIMEOUT_EN
    exp_g_a = 4'b0000;
    exp_f_a = 1'b1;
    exp_g_b = 4'b0100;
`else
    exp_g_a = 4'b0010;
    exp_f_a = 1'b0;
    exp_g_b = 4'b0010;
`endif
    do_reset();
    load(1, 0, 1'b0, 8'h21);
    load(2, 0, 1'b1, 8'h31);
    run_until_out("to_first_byte", 1, 20);
    check("to_owner", grant_log[0], 4'b0010);
    repeat (8) step();
    check("to_hold_grant", grant, 4'b0010);
    check("to_hold_flag", timeout_flag, 1'b0);
    step();
    check("to_release_grant", grant, exp_g_a);
    check("to_release_flag", timeout_flag, exp_f_a);
    step();
    check("to_next_grant", grant, exp_g_b);
    repeat (4) step();
    check("to_flag_sticky", timeout_flag, exp_f_a);

    check("no_foreign_ack", bad_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
